// File: rtl/clic_gateway.sv
// Per-source CLIC interrupt gateway: level/edge qualification into pending bits.
// Define CLIC_GW_SYNC_EN to insert SYNC_STAGES-deep input synchronisers.
module clic_gateway #(
  parameter int unsigned N_SOURCE    = 32,
  parameter int unsigned SYNC_STAGES = 2,
  localparam int unsigned ID_W       = $clog2(N_SOURCE)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [N_SOURCE-1:0]      intr_src_i,
  input  logic [N_SOURCE-1:0][1:0] trig_i,
  input  logic [N_SOURCE-1:0]      ie_i,
  input  logic                     sw_we_i,
  input  logic [ID_W-1:0]          sw_idx_i,
  input  logic                     sw_val_i,
  input  logic                     ack_valid_i,
  input  logic [ID_W-1:0]          ack_id_i,
  output logic [N_SOURCE-1:0]      ip_o,
  output logic [N_SOURCE-1:0]      req_o
);

  if (N_SOURCE < 2 || SYNC_STAGES < 2) begin : g_param_check
    $error("clic_gateway: N_SOURCE and SYNC_STAGES must both be >= 2");
  end

  logic [N_SOURCE-1:0] s;
  logic [N_SOURCE-1:0] prev_q;
  logic [N_SOURCE-1:0] evt_q;
  logic [N_SOURCE-1:0] evt_d;
  logic [N_SOURCE-1:0] ip_q;
  logic [N_SOURCE-1:0] ip_d;

`ifdef CLIC_GW_SYNC_EN
  logic [SYNC_STAGES-1:0][N_SOURCE-1:0] sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= intr_src_i;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
    end
  end

  assign s = sync_q[SYNC_STAGES-1];
`else
  assign s = intr_src_i;
`endif

  // Edges are captured into evt_q first, so the edge path lands one cycle after the level path.
  always_comb begin
    evt_d = '0;
    ip_d  = ip_q;
    for (int i = 0; i < N_SOURCE; i++) begin
      evt_d[i] = trig_i[i][0] &
                 (trig_i[i][1] ? (prev_q[i] & ~s[i]) : (~prev_q[i] & s[i]));
      if (!trig_i[i][0]) begin
        ip_d[i] = s[i] ^ trig_i[i][1];
      end else if (evt_q[i]) begin
        ip_d[i] = 1'b1;
      end else if (sw_we_i && (sw_idx_i == ID_W'(i))) begin
        ip_d[i] = sw_val_i;
      end else if (ack_valid_i && (ack_id_i == ID_W'(i))) begin
        ip_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prev_q <= '0;
      evt_q  <= '0;
      ip_q   <= '0;
    end else begin
      prev_q <= s;
      evt_q  <= evt_d;
      ip_q   <= ip_d;
    end
  end

  assign ip_o  = ip_q;
  assign req_o = ip_q & ie_i;

endmodule

// File: tb/tb_clic_gateway.sv
// Self-checking bench for clic_gateway: directed scenarios plus randomized traffic
// compared every cycle against an input-history reference model.
module tb_clic_gateway;

`ifdef CLIC_GW_SYNC_EN
  localparam int D = 2;
`else
  localparam int D = 0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [31:0]      intr;
  logic [31:0][1:0] trig;
  logic [31:0]      ie;
  logic             sw_we;
  logic [4:0]       sw_idx;
  logic             sw_val;
  logic             ack_valid;
  logic [4:0]       ack_id;
  logic [31:0]      ip;
  logic [31:0]      req;

  logic [19:0]      intr_b;
  logic [19:0][1:0] trig_b;
  logic [19:0]      ie_b;
  logic             sw_we_b;
  logic [4:0]       sw_idx_b;
  logic             sw_val_b;
  logic             ack_valid_b;
  logic [4:0]       ack_id_b;
  logic [19:0]      ip_b;
  logic [19:0]      req_b;

  int vectors = 0;
  int errs    = 0;

  logic [31:0] hist[$];
  logic [31:0] m_ip;
  logic [31:0] m_evt;

  always #5 clk = ~clk;

  clic_gateway #(.N_SOURCE(32), .SYNC_STAGES(2)) u_dut (
    .clk_i(clk), .rst_i(rst), .intr_src_i(intr), .trig_i(trig), .ie_i(ie),
    .sw_we_i(sw_we), .sw_idx_i(sw_idx), .sw_val_i(sw_val),
    .ack_valid_i(ack_valid), .ack_id_i(ack_id), .ip_o(ip), .req_o(req)
  );

  clic_gateway #(.N_SOURCE(20), .SYNC_STAGES(2)) u_small (
    .clk_i(clk), .rst_i(rst), .intr_src_i(intr_b), .trig_i(trig_b), .ie_i(ie_b),
    .sw_we_i(sw_we_b), .sw_idx_i(sw_idx_b), .sw_val_i(sw_val_b),
    .ack_valid_i(ack_valid_b), .ack_id_i(ack_id_b), .ip_o(ip_b), .req_o(req_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ip  = '0;
    m_evt = '0;
    hist.delete();
    repeat (D + 2) hist.push_back('0);
  endtask

  // Pending behaviour derived from the raw input history delayed by D cycles.
  task automatic model_clock();
    logic [31:0] sv, pv, nxt, ev;
    hist.push_back(intr);
    sv = hist[hist.size() - 1 - D];
    pv = hist[hist.size() - 2 - D];
    for (int i = 0; i < 32; i++) begin
      if (trig[i][0] == 1'b0)                      nxt[i] = sv[i] ^ trig[i][1];
      else if (m_evt[i])                           nxt[i] = 1'b1;
      else if (sw_we && sw_idx == 5'(i))           nxt[i] = sw_val;
      else if (ack_valid && ack_id == 5'(i))       nxt[i] = 1'b0;
      else                                         nxt[i] = m_ip[i];
      ev[i] = trig[i][0] && (sv[i] != pv[i]) && (sv[i] == ~trig[i][1]);
    end
    m_ip  = nxt;
    m_evt = ev;
    while (hist.size() > D + 2) void'(hist.pop_front());
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    if (!rst) model_clock();
    #1;
    chk({tag, "_ip"}, ip, m_ip);
    chk({tag, "_req"}, req, m_ip & ie);
  endtask

  initial begin
    rst = 1'b1; intr = '0; trig = '0; ie = '0;
    sw_we = 1'b0; sw_idx = '0; sw_val = 1'b0; ack_valid = 1'b0; ack_id = '0;
    intr_b = '0; ie_b = '1; sw_we_b = 1'b0; sw_idx_b = '0; sw_val_b = 1'b0;
    ack_valid_b = 1'b0; ack_id_b = '0;
    for (int i = 0; i < 20; i++) trig_b[i] = 2'b01;
    model_reset();
    #3;
    chk("reset_ip", ip, 32'h0);
    chk("reset_req", req, 32'h0);
    tick("in_reset");
    @(negedge clk); rst = 1'b0;
    tick("idle");

    // Source 3, positive edge: one-cycle pulse, then ack
    trig[3] = 2'b01;
    intr[3] = 1'b1; tick("s3_pulse"); intr[3] = 1'b0;
    repeat (D) tick("s3_wait");
    chk1("s3_not_yet", ip[3], 1'b0);
    tick("s3_set");
    chk1("s3_set", ip[3], 1'b1);
    repeat (3) tick("s3_hold");
    chk1("s3_hold", ip[3], 1'b1);
    ack_valid = 1'b1; ack_id = 5'd3; tick("s3_ack"); ack_valid = 1'b0;
    chk1("s3_ack", ip[3], 1'b0);

    // Source 5, negative level
    trig[5] = 2'b10;
    tick("s5_low");
    chk1("s5_low", ip[5], 1'b1);
    intr[5] = 1'b1;
    repeat (D) tick("s5_rise");
    chk1("s5_still", ip[5], 1'b1);
    tick("s5_drop");
    chk1("s5_drop", ip[5], 1'b0);
    sw_we = 1'b1; sw_idx = 5'd5; sw_val = 1'b1; tick("s5_sw"); sw_we = 1'b0;
    chk1("s5_sw_ignored", ip[5], 1'b0);

    // Source 7: edge arrival and ack on the same cycle
    trig[7] = 2'b01;
    intr[7] = 1'b1; tick("s7_rise");
    repeat (D) tick("s7_wait");
    ack_valid = 1'b1; ack_id = 5'd7; tick("s7_edge_ack"); ack_valid = 1'b0;
    chk1("s7_edge_beats_ack", ip[7], 1'b1);
    ack_valid = 1'b1; tick("s7_ack"); ack_valid = 1'b0;
    chk1("s7_ack", ip[7], 1'b0);

    // Source 9: software write and enable gating
    trig[9] = 2'b01; ie[9] = 1'b1;
    sw_we = 1'b1; sw_idx = 5'd9; sw_val = 1'b1; tick("s9_sw"); sw_we = 1'b0;
    chk1("s9_ip", ip[9], 1'b1);
    chk1("s9_req", req[9], 1'b1);
    ie[9] = 1'b0; #1;
    chk1("s9_req_gated", req[9], 1'b0);
    chk1("s9_ip_kept", ip[9], 1'b1);
    sw_we = 1'b1; sw_val = 1'b0; ack_valid = 1'b1; ack_id = 5'd9; tick("s9_sw0_ack");
    chk1("s9_sw0_ack", ip[9], 1'b0);
    sw_val = 1'b1; tick("s9_sw1_ack"); sw_we = 1'b0; ack_valid = 1'b0;
    chk1("s9_sw1_ack", ip[9], 1'b1);

    // Source 2: level->edge switch and polarity flip on a steady input
    intr[2] = 1'b1;
    repeat (D + 2) tick("s2_level");
    chk1("s2_level", ip[2], 1'b1);
    trig[2] = 2'b01; repeat (3) tick("s2_to_edge");
    chk1("s2_kept", ip[2], 1'b1);
    ack_valid = 1'b1; ack_id = 5'd2; tick("s2_ack"); ack_valid = 1'b0;
    trig[2] = 2'b11; repeat (D + 3) tick("s2_flip");
    chk1("s2_flip_no_edge", ip[2], 1'b0);
    trig[2] = 2'b01; repeat (D + 3) tick("s2_flip_back");
    chk1("s2_flip_back", ip[2], 1'b0);

    // Out-of-range indices on a 20-source gateway
    sw_we_b = 1'b1; sw_idx_b = 5'd4; sw_val_b = 1'b1; tick("b_sw"); sw_we_b = 1'b0;
    chk("b_sw", 32'(ip_b), 32'h10);
    ack_valid_b = 1'b1; ack_id_b = 5'd31; tick("b_ack31"); ack_valid_b = 1'b0;
    chk("b_ack31", 32'(ip_b), 32'h10);
    sw_we_b = 1'b1; sw_idx_b = 5'd25; tick("b_sw25"); sw_we_b = 1'b0;
    chk("b_sw25", 32'(ip_b), 32'h10);
    ack_valid_b = 1'b1; ack_id_b = 5'd4; tick("b_ack4"); ack_valid_b = 1'b0;
    chk("b_ack4", 32'(ip_b), 32'h0);

    // Asynchronous reset mid-pulse, source high at release
    intr[3] = 1'b1; tick("r_pulse");
    chk("r_before_nonzero", 32'(ip != 32'h0), 32'h1);
    #2 rst = 1'b1; model_reset();
    #1 chk("r_async_ip", ip, 32'h0);
    tick("r_held");
    @(negedge clk); rst = 1'b0;
    repeat (D + 1) tick("r_release");
    chk1("r_s3_not_yet", ip[3], 1'b0);
    tick("r_s3_set");
    chk1("r_s3_one_pending", ip[3], 1'b1);
    ack_valid = 1'b1; ack_id = 5'd3; tick("r_s3_ack"); ack_valid = 1'b0;
    repeat (D + 3) tick("r_s3_quiet");
    chk1("r_s3_no_repeat", ip[3], 1'b0);

    // Randomized traffic against the model
    for (int i = 0; i < 32; i++) trig[i] = 2'($urandom_range(0, 3));
    for (int c = 0; c < 600; c++) begin
      intr = intr ^ ($urandom() & $urandom() & $urandom());
      if ($urandom_range(0, 15) == 0) begin
        int j;
        j = int'($urandom_range(0, 31));
        trig[j] = 2'($urandom_range(0, 3));
      end
      ie        = $urandom();
      sw_we     = ($urandom_range(0, 3) == 0);
      sw_idx    = 5'($urandom_range(0, 31));
      sw_val    = 1'($urandom_range(0, 1));
      ack_valid = ($urandom_range(0, 2) == 0);
      ack_id    = 5'($urandom_range(0, 31));
      tick("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
